// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (I) and load/store (D).
// One transaction in flight; responses are routed to their owner and squashed fetches are dropped.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  input  logic              i_flush,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       drop;
  logic       wr_flag;

  logic can_grant;
  logic pick_i;
  logic grant_i;
  logic grant_d;

  // A new grant may overlap the response cycle of the current transaction.
  always_comb begin
    can_grant = rst && m_ready && (i_req || d_req) &&
                ((state == IDLE) || (((state == WAIT_I) || (state == WAIT_D)) && m_rvalid));
    pick_i    = i_req && (!d_req || (starve_cnt == STARVE_LIM));
    grant_i   = can_grant && pick_i;
    grant_d   = can_grant && !pick_i && d_req;
  end

  always_comb begin
    i_ready  = grant_i;
    d_ready  = grant_d;
    m_req    = grant_i || grant_d;
    m_we     = grant_d && d_we;
    m_wstrb  = (grant_d && d_we) ? d_wstrb : 4'b0000;
    m_wdata  = (grant_d && d_we) ? d_wdata : '0;
    m_addr   = grant_i ? i_addr : (grant_d ? d_addr : '0);

    // A flush coinciding with the response still squashes it.
    i_rvalid = rst && (state == WAIT_I) && m_rvalid && !drop && !i_flush;
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rvalid = rst && (state == WAIT_D) && m_rvalid;
    d_rdata  = (d_rvalid && !wr_flag) ? m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      drop       <= 1'b0;
      wr_flag    <= 1'b0;
    end else begin
      if (grant_i) begin
        state <= WAIT_I;
      end else if (grant_d) begin
        state <= WAIT_D;
      end else begin
        case (state)
          IDLE:           state <= IDLE;
          WAIT_I, WAIT_D: state <= m_rvalid ? IDLE : state;
          default:        state <= IDLE;
        endcase
      end

      if (!i_req || grant_i) begin
        starve_cnt <= 4'd0;
      end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (grant_i) begin
        drop <= i_flush;
      end else if (state == WAIT_I) begin
        if (m_rvalid) begin
          drop <= 1'b0;
        end else if (i_flush) begin
          drop <= 1'b1;
        end
      end else begin
        drop <= 1'b0;
      end

      if (grant_d) begin
        wr_flag <= d_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard of expected grants and responses,
// a behavioural memory with programmable latency, and a negedge monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_ready, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_flush(i_flush),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard queues: grant record {i_ready,d_ready,m_req,m_we,m_wstrb,m_addr,m_wdata} with mask.
  logic [71:0] gq[$];
  logic [71:0] gm[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  localparam logic [71:0] MASK_RD = {40'hFF_FFFF_FFFF, 32'h0};
  localparam logic [71:0] MASK_WR = {72{1'b1}};

  task automatic push_i(input logic [31:0] a);
    gq.push_back({1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, a, 32'h0});
    gm.push_back(MASK_RD);
  endtask

  task automatic push_dr(input logic [31:0] a);
    gq.push_back({1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, a, 32'h0});
    gm.push_back(MASK_RD);
  endtask

  task automatic push_dw(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    gq.push_back({1'b0, 1'b1, 1'b1, 1'b1, s, a, w});
    gm.push_back(MASK_WR);
  endtask

  // Behavioural memory: response appears lat cycles after the grant cycle.
  logic [31:0] mem [0:63];
  int          lat = 1;
  int          rem = 0;
  logic [31:0] pend = 32'h0;

  always @(posedge clk) begin
    if (m_req && m_ready) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem[m_addr[7:2]][8*b +: 8] = m_wdata[8*b +: 8];
        pend = 32'h0;
      end else begin
        pend = mem[m_addr[7:2]];
      end
      rem = lat;
    end else if (rem > 0) begin
      rem = rem - 1;
    end
    m_rvalid <= (rem == 1);
    m_rdata  <= (rem == 1) ? pend : 32'h0;
  end

  // Monitor: compares every grant and response against the scoreboard.
  always @(negedge clk) begin
    logic [71:0] act, e, m;
    act = {i_ready, d_ready, m_req, m_we, m_wstrb, m_addr, m_wdata};
    if (i_ready || d_ready || m_req) begin
      if (gq.size() == 0) check("grant_extra", 160'(act), 160'h0);
      else begin
        e = gq.pop_front();
        m = gm.pop_front();
        check("grant", 160'(act & m), 160'(e));
      end
    end
    if (i_rvalid) begin
      if (iq.size() == 0) check("i_rvalid_extra", 160'(i_rvalid), 160'h0);
      else check("i_rdata", 160'(i_rdata), 160'(iq.pop_front()));
    end
    if (d_rvalid) begin
      if (dq.size() == 0) check("d_rvalid_extra", 160'(d_rvalid), 160'h0);
      else check("d_rdata", 160'(d_rdata), 160'(dq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string nm, output logic rv);
    int n;
    n  = 0;
    rv = 1'b0;
    @(negedge clk);
    while (!(i_ready || d_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(i_ready || d_ready)) check(nm, 160'h0, 160'h1);
    rv = m_rvalid;
    tick();
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
                 m_req, m_we, m_wstrb, m_addr, m_wdata});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic rv;
    int   n;
    for (int k = 0; k < 64; k++) mem[k] = 32'h0;
    mem[0]  = 32'h1111_2222;
    mem[16] = 32'h0000_0013;
    mem[17] = 32'h00A0_0093;
    mem[18] = 32'h00B0_0113;

    rst = 1'b0; m_ready = 1'b1; i_flush = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
    #3;
    check("reset_outs", all_outs(), 160'h0);
    tick();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) tick();

    // Single fetch
    push_i(32'h40); iq.push_back(32'h0000_0013);
    i_req = 1'b1; i_addr = 32'h40;
    wait_grant("t1_timeout", rv);
    i_req = 1'b0;
    repeat (3) tick();

    // Simultaneous requests: D,D,D,D,I then D again once the counter cleared
    for (int k = 0; k < 4; k++) begin push_dr(32'h2000); dq.push_back(32'h1111_2222); end
    push_i(32'h44); iq.push_back(32'h00A0_0093);
    push_dr(32'h2000); dq.push_back(32'h1111_2222);
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b0;
    for (int k = 0; k < 6; k++) wait_grant("t2_timeout", rv);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();

    // Store with partial strobes, then read it back
    push_dw(32'h2004, 4'b0011, 32'hDEAD_BEEF); dq.push_back(32'h0);
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF;
    wait_grant("t3w_timeout", rv);
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'b0000; d_wdata = 32'h0;
    repeat (2) tick();
    push_dr(32'h2004); dq.push_back(32'h0000_BEEF);
    d_req = 1'b1; d_addr = 32'h2004;
    wait_grant("t3r_timeout", rv);
    d_req = 1'b0;
    repeat (3) tick();

    // Flush with latency 3; new fetch granted in the dropped response cycle
    lat = 3;
    push_i(32'h48);
    push_i(32'h40); iq.push_back(32'h0000_0013);
    i_req = 1'b1; i_addr = 32'h48;
    wait_grant("t4a_timeout", rv);
    i_req = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_req = 1'b1; i_addr = 32'h40; lat = 1;
    wait_grant("t4b_timeout", rv);
    check("t4_b2b_grant", 160'(rv), 160'h1);
    i_req = 1'b0;
    repeat (3) tick();

    // Back-pressure
    m_ready = 1'b0;
    push_dr(32'h2000); dq.push_back(32'h1111_2222);
    push_i(32'h40); iq.push_back(32'h0000_0013);
    i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_held", 160'({m_req, i_ready, d_ready}), 160'h0);
    end
    tick();
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_first_grant", 160'({i_ready, d_ready}), 160'b01);
    tick();
    d_req = 1'b0;
    wait_grant("t5_timeout", rv);
    i_req = 1'b0;
    repeat (3) tick();

    // Reset while a read is outstanding
    lat = 3;
    push_dr(32'h2000);
    d_req = 1'b1; d_addr = 32'h2000;
    wait_grant("t6a_timeout", rv);
    i_req = 1'b1; i_addr = 32'h40;
    rst = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 160'h0);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_rvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("late_rvalid_seen", 160'(m_rvalid), 160'h1);
    check("late_rvalid_ignored", 160'({i_rvalid, d_rvalid}), 160'h0);
    tick();
    lat = 1;
    push_dr(32'h2004); dq.push_back(32'h0000_BEEF);
    d_req = 1'b1; d_addr = 32'h2004;
    wait_grant("t6b_timeout", rv);
    d_req = 1'b0;
    repeat (5) tick();

    check("scoreboard_drained", 160'(gq.size() + iq.size() + dq.size()), 160'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Sits between the Core pipeline stages and the memory array.
- Grants one transaction at a time, routes each response back to its owner, and drops squashed fetches on flush.
- Data accesses normally win; a starvation guard makes sure fetch is not locked out.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive D grants while I is waiting before I is forced to win (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_req  in  1  fetch request valid.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  fetch request accepted this cycle.
- i_flush  in  1  discard any outstanding fetch response.
- i_rvalid  out  1  fetch data valid, one-cycle pulse.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request valid.
- d_we  in  1  write (1) or read (0).
- d_wstrb  in  4  byte enables for a write.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  data request accepted.
- d_rvalid  out  1  data read data or write acknowledge, one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 on a write ack.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_wstrb  out  4  memory byte enables; 0 for a read.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_ready  in  1  memory can accept a request.
- m_rvalid  in  1  memory response valid; latency 1 or more cycles.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, WAIT_I, WAIT_D. At most one transaction is outstanding.
- Grant condition: a grant happens in IDLE, or in WAIT_x in the same cycle m_rvalid arrives (back-to-back), when m_ready=1 and at least one request is pending.
- Grant effects:
  - The m_* outputs are driven combinationally from the winner.
  - The winner's ready is driven high for that cycle only.
  - Next state is WAIT_I or WAIT_D.
  - With no grant, the FSM completes to IDLE.
- Priority:
  - D wins a simultaneous request, unless starve_cnt == STARVE_MAX; then I wins.
  - starve_cnt increments on each D grant while i_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on any I grant, or in any cycle where i_req=0.
- Request holding: requesters hold req and payload stable until ready. Losing requests are not latched.
- Response routing:
  - In WAIT_I with m_rvalid: i_rvalid=1 and i_rdata=m_rdata in the same cycle (combinational).
  - In WAIT_D with m_rvalid: d_rvalid=1; d_rdata=m_rdata for a read, 0 for a write (write flag registered at grant).
  - In IDLE, m_rvalid is ignored.
- Flush:
  - i_flush=1 while in WAIT_I, or in the cycle of an I grant, sets a drop flag.
  - The matching response is consumed, but i_rvalid is suppressed.
  - The drop flag clears when that response arrives.
  - i_flush has no effect on D.
- Latency: with a 1-cycle memory, the response pulse comes 1 cycle after the ready cycle. Sustained throughput is 1 transaction per cycle.
- Outputs gated off:
  - When m_ready=0: no grant, both readies 0, m_req=0.
  - m_req is never asserted without a grant.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; starve_cnt and the drop flag go to 0.
  - All outputs read 0 while rst=0.
  - A memory response still in flight when reset releases is ignored, because the FSM is in IDLE.
- Unused or illegal FSM encoding: returns to IDLE.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, memory returns 0x00000013 after 1 cycle -> i_ready pulses at t0, i_rvalid=1 with i_rdata=0x00000013 at t1, d_* stay 0.
- Simultaneous requests: i_req and d_req (read 0x2000) both held, STARVE_MAX=4 -> grant order D,D,D,D,I; starve_cnt reaches 4, then clears after the I grant; every response is routed to its correct owner.
- Store: d_we=1, d_wstrb=4'b0011, d_wdata=0xDEADBEEF, addr 0x2004 -> m_we=1 and m_wstrb=0011 in the grant cycle; next cycle d_rvalid=1 with d_rdata=0.
- Flush: I granted at t0, i_flush=1 at t1, memory latency 3 -> no i_rvalid pulse; a new I request at the response cycle is granted and returns its data normally.
- Back-pressure: m_ready=0 for 5 cycles with both requests pending -> m_req=0 and both readies 0 throughout; first grant occurs in the cycle m_ready rises.
- Reset mid-operation: rst low during WAIT_D -> all outputs 0 immediately; after release, a late m_rvalid=1 produces no d_rvalid, and the FSM accepts the next request.
